tile_spawner: RTL

TILE_SPAWNER -- requirements
Module: tile_spawner

---
 rtl/tile_pkg.sv | 17 +
 rtl/tile_spawner.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/tile_pkg.sv
// Shared constants, board type and FSM state encoding for the tile spawner.
package tile_pkg;
    localparam int N_CELLS  = 16;
    localparam int CELL_W   = 4;
    localparam logic [CELL_W-1:0] EXP_TWO  = 4'd1;
    localparam logic [CELL_W-1:0] EXP_FOUR = 4'd2;

    typedef logic [N_CELLS-1:0][CELL_W-1:0] board_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_MOD   = 3'd2,
        S_PLACE = 3'd3,
        S_DONE  = 3'd4
    } state_e;
endpackage

// File: rtl/tile_spawner.sv
// Places a new 2- or 4-tile in a pseudo-randomly chosen empty cell of a 4x4 board.
// The 4-tile option is built only when TILE_SPAWNER_FOUR_EN is defined.
module tile_spawner
    import tile_pkg::*;
#(
    parameter logic [7:0] FOUR_THRESH = 8'd26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rand_num,
    input  logic [63:0] board_in,
    output logic        busy,
    output logic        done,
    output logic        full,
    output logic [3:0]  spawn_idx,
    output logic [3:0]  spawn_exp,
    output logic [63:0] board_out
);

    state_e            state_q, state_d;
    board_t            board_q, board_d;
    logic [7:0]        rand_q, rand_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [3:0]        idx_q, idx_d;
    logic [3:0]        r_q, r_d;
    logic              full_q, full_d;
    logic [3:0]        sidx_q, sidx_d;
    logic [CELL_W-1:0] sexp_q, sexp_d;
    board_t            bout_q, bout_d;

    logic              cell_empty;
    logic [CELL_W-1:0] new_exp;

    assign cell_empty = (board_q[idx_q] == '0);

`ifdef TILE_SPAWNER_FOUR_EN
    assign new_exp = (rand_q < FOUR_THRESH) ? EXP_FOUR : EXP_TWO;
`else
    logic unused_four;
    assign unused_four = ^{rand_q[7:4], FOUR_THRESH, EXP_FOUR};
    assign new_exp     = EXP_TWO;
`endif

    always_comb begin
        state_d = state_q;
        board_d = board_q;
        rand_d  = rand_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        r_d     = r_q;
        full_d  = full_q;
        sidx_d  = sidx_q;
        sexp_d  = sexp_q;
        bout_d  = bout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    board_d = board_t'(board_in);
                    rand_d  = rand_num;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                cnt_d = cnt_q + {4'd0, cell_empty};
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'(N_CELLS - 1)) begin
                    if (cnt_d == '0) begin
                        full_d  = 1'b1;
                        bout_d  = board_q;
                        state_d = S_DONE;
                    end else begin
                        r_d     = rand_q[3:0];
                        state_d = S_MOD;
                    end
                end
            end
            S_MOD: begin
                // Repeated subtraction: r ends as rand[3:0] mod cnt
                if ({1'b0, r_q} >= cnt_q) begin
                    r_d = r_q - cnt_q[3:0];
                end else begin
                    idx_d   = '0;
                    state_d = S_PLACE;
                end
            end
            S_PLACE: begin
                idx_d = idx_q + 4'd1;
                if (cell_empty) begin
                    if (r_q == '0) begin
                        bout_d         = board_q;
                        bout_d[idx_q]  = new_exp;
                        full_d         = 1'b0;
                        sidx_d         = idx_q;
                        sexp_d         = new_exp;
                        state_d        = S_DONE;
                    end else begin
                        r_d = r_q - 4'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            board_q <= '0;
            rand_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            r_q     <= '0;
            full_q  <= 1'b0;
            sidx_q  <= '0;
            sexp_q  <= '0;
            bout_q  <= '0;
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            rand_q  <= rand_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            r_q     <= r_d;
            full_q  <= full_d;
            sidx_q  <= sidx_d;
            sexp_q  <= sexp_d;
            bout_q  <= bout_d;
        end
    end

    assign busy      = (state_q == S_COUNT) || (state_q == S_MOD) || (state_q == S_PLACE);
    assign done      = (state_q == S_DONE);
    assign full      = full_q;
    assign spawn_idx = sidx_q;
    assign spawn_exp = sexp_q;
    assign board_out = 64'(bout_q);

endmodule
